scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output and two modes. Manual mode selects a channel from an external select. Auto mode round-robins over the enabled channels, dwelling a programmable number of cycles on each. Used to time-share one datapath or display driver across several sources; it generalises the fixed 4-to-1, 4-bit combinational mux.

Parameters:
W, 4, data width per channel in bits
N, 4, number of input channels (N >= 2)
SELW, $clog2(N), width of channel index
DWELL_W, 16, width of the dwell-count input

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = manual select, 1 = auto round-robin scan
sel_in  input  SELW  channel index used in manual mode
en_mask  input  N  per-channel enable for auto mode (bit i = channel i)
dwell  input  DWELL_W  cycles spent on each channel in auto mode; 0 is treated as 1
d_in  input  N*W  flattened channel data; channel i occupies bits [i*W +: W]
y  output  W  registered selected data
sel_out  output  SELW  channel index currently driving y
y_valid  output  1  y holds data from a legal, selected channel
wrap  output  1  one-cycle pulse when auto scan returns to a lower-or-equal index

Behaviour:
- Reset (async, immediate): y=0, sel_out=0, y_valid=0, wrap=0, dwell counter=0, state=MANUAL. Reset mid-scan aborts the scan with no further wrap pulse.
- y and sel_out update together. y(t+1) = d_in[sel_out(t+1)] sampled at edge t, giving 1-cycle latency from d_in/sel_in to y.
- States:
  - MANUAL: when mode=0.
  - SCAN: when mode=1 and en_mask != 0.
  - HALT: when mode=1 and en_mask == 0.
  - State is re-evaluated every cycle from mode and en_mask.
- MANUAL:
  - sel_in < N: sel_out <= sel_in; y <= channel data; y_valid <= 1.
  - sel_in >= N (possible only when N is not a power of 2): sel_out holds; y <= 0; y_valid <= 0.
  - Dwell counter is held at 0. wrap = 0.
- Entering SCAN (from MANUAL or HALT):
  - Counter cleared.
  - sel_out <= first enabled channel at or after the current sel_out, searching upward with wrap modulo N.
  - y_valid <= 1.
  - No wrap pulse on entry.
- SCAN steady state:
  - Counter increments each cycle.
  - When counter == max(dwell,1)-1: counter <= 0, sel_out <= next enabled channel strictly after sel_out (modulo N).
  - wrap <= 1 for exactly that cycle if the new index <= old index. This includes the single-enabled-channel case, where wrap pulses every dwell period.
  - If the current channel's en_mask bit is cleared mid-dwell, advance on the next edge regardless of the counter and reset the counter. The wrap rule applies to this advance.
  - dwell changes take effect at the next comparison. If the counter is already >= the new dwell-1, advance on the next edge.
- HALT: y <= 0, y_valid <= 0, sel_out holds, counter <= 0, wrap = 0.
- Switching SCAN -> MANUAL: takes effect on the next edge, counter cleared, wrap = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then manual mode, N=4, W=4, d_in={3:4'h9, 2:4'h3, 1:4'h6, 0:4'hC}; step sel_in 0,1,2,3 one per cycle -> y = C,6,3,9 one cycle later; sel_out tracks; y_valid=1.
2. Auto, en_mask=4'b1111, dwell=3 -> sel_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap high exactly on the cycle sel_out returns to 0; y follows live d_in changes within 1 cycle.
3. Auto, en_mask=4'b1010, dwell=2 -> sel_out 1,1,3,3,1,...; wrap on each 3->1 transition. Then clear bit 3 while on channel 3 -> sel_out=1 on the next edge, with wrap.
4. Auto, dwell=0, en_mask=4'b0001 -> sel_out stays 0, wrap pulses every cycle. Then en_mask=0 -> y=0, y_valid=0, sel_out held at 0.
5. Mid-scan (sel_out=2, counter=1) assert rst asynchronously between edges -> all outputs 0 immediately. Release with mode=1, en_mask=4'b1111, dwell=2 -> scan restarts at channel 0, no spurious wrap.
6. Manual sel_in=2, switch mode=1 with en_mask=4'b1001 -> sel_out=3 on the next edge (first enabled at or after 2), no wrap. After dwell expires -> sel_out=0 with wrap=1.

Source files
------------

// File: rtl/scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : scan_mux
//  Purpose  : N-channel, W-bit multiplexer with a registered output. Manual
//             mode selects a channel from sel_in. Auto mode round-robins over
//             the enabled channels and dwells a programmable number of cycles
//             on each one. A scan wrap is flagged with a one-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_mux #(
  parameter int W       = 4,
  parameter int N       = 4,
  parameter int SELW    = $clog2(N),
  parameter int DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic [N-1:0]         en_mask,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [N*W-1:0]       d_in,
  output logic [W-1:0]         y,
  output logic [SELW-1:0]      sel_out,
  output logic                 y_valid,
  output logic                 wrap
);

  // Operating modes, re-derived every cycle from mode and en_mask.
  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] c_dwell_zero = '0;
  localparam logic [DWELL_W-1:0] c_dwell_one  = DWELL_W'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic [DWELL_W-1:0]   r_cnt;
  logic [W-1:0]         r_y;
  logic [SELW-1:0]      r_sel_out;
  logic                 r_y_valid;
  logic                 r_wrap;

  logic [W-1:0]         w_ch [N];
  logic                 w_sel_in_ok;
  logic [SELW-1:0]      w_first_sel;
  logic [SELW-1:0]      w_step_sel;
  logic [DWELL_W-1:0]   w_limit;
  logic                 w_cnt_done;
  logic                 w_cur_en;
  logic                 w_advance;

  // Unpack the flattened data bus into one word per channel.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_ch[gi] = d_in[gi*W +: W];
    end
  endgenerate

  // Circular search for the first enabled channel, starting `offset` places
  // after `from`. offset=0 includes `from` itself; offset=1 excludes it.
  // The caller guarantees at least one mask bit is set.
  function automatic logic [SELW-1:0] f_search(
    input logic [SELW-1:0] from,
    input logic [N-1:0]    mask,
    input int              offset
  );
    logic [SELW-1:0] res;
    logic [SELW-1:0] idx_sel;
    logic            found;
    int              idx;
    res   = from;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(from) + k + offset;
      if (idx >= N) idx = idx - N;
      idx_sel = idx[SELW-1:0];
      if (!found && mask[idx_sel]) begin
        res   = idx_sel;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Out-of-range manual selects only exist when N is not a power of two.
  assign w_sel_in_ok = (32'(sel_in) < 32'(N));

  // Candidate indices for scan entry and for a dwell-expiry step.
  assign w_first_sel = f_search(r_sel_out, en_mask, 0);
  assign w_step_sel  = f_search(r_sel_out, en_mask, 1);

  // A dwell of zero behaves as one; >= catches a dwell shrunk mid-period.
  assign w_limit    = (dwell == c_dwell_zero) ? c_dwell_zero : (dwell - c_dwell_one);
  assign w_cnt_done = (r_cnt >= w_limit);
  assign w_cur_en   = en_mask[r_sel_out];
  assign w_advance  = w_cnt_done || !w_cur_en;

  // Decode the mode for the coming edge.
  always_comb begin
    w_next_state = ST_MANUAL;
    if (mode) begin
      w_next_state = (|en_mask) ? ST_SCAN : ST_HALT;
    end
  end

  // Registered datapath, channel pointer, dwell counter and wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_MANUAL;
      r_cnt     <= '0;
      r_y       <= '0;
      r_sel_out <= '0;
      r_y_valid <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      unique case (w_next_state)
        ST_MANUAL: begin
          r_cnt  <= '0;
          r_wrap <= 1'b0;
          if (w_sel_in_ok) begin
            r_sel_out <= sel_in;
            r_y       <= w_ch[sel_in];
            r_y_valid <= 1'b1;
          end else begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_y_valid <= 1'b1;
          if (r_state != ST_SCAN) begin
            // Fresh entry: land on the nearest enabled channel, no wrap.
            r_cnt     <= '0;
            r_sel_out <= w_first_sel;
            r_y       <= w_ch[w_first_sel];
            r_wrap    <= 1'b0;
          end else if (w_advance) begin
            r_cnt     <= '0;
            r_sel_out <= w_step_sel;
            r_y       <= w_ch[w_step_sel];
            r_wrap    <= (w_step_sel <= r_sel_out);
          end else begin
            r_cnt     <= r_cnt + c_dwell_one;
            r_y       <= w_ch[r_sel_out];
            r_wrap    <= 1'b0;
          end
        end
        default: begin
          // Halt: nothing enabled, output blanked, pointer kept.
          r_cnt     <= '0;
          r_y       <= '0;
          r_y_valid <= 1'b0;
          r_wrap    <= 1'b0;
        end
      endcase
    end
  end

  assign y       = r_y;
  assign sel_out = r_sel_out;
  assign y_valid = r_y_valid;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_scan_mux
//  Purpose  : Scoreboard bench for scan_mux (N=4, W=4). The driver pushes the
//             expected post-edge outputs; a monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

  localparam int W    = 4;
  localparam int N    = 4;
  localparam int SELW = 2;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SELW-1:0]   sel_in;
  logic [N-1:0]      en_mask;
  logic [DW-1:0]     dwell;
  logic [N*W-1:0]    d_in;
  logic [W-1:0]      y;
  logic [SELW-1:0]   sel_out;
  logic              y_valid;
  logic              wrap;

  typedef struct {
    logic [W-1:0]    y;
    logic [SELW-1:0] sel;
    logic            v;
    logic            w;
    string           tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  scan_mux #(.W(W), .N(N), .SELW(SELW), .DWELL_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .sel_in  (sel_in),
    .en_mask (en_mask),
    .dwell   (dwell),
    .d_in    (d_in),
    .y       (y),
    .sel_out (sel_out),
    .y_valid (y_valid),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Channel data the DUT should sample at the coming edge.
  function automatic logic [W-1:0] ch(input logic [SELW-1:0] s);
    logic [N*W-1:0] bus;
    bus = d_in;
    return bus[s*W +: W];
  endfunction

  // Push the expected post-edge outputs, then move past the edge.
  task automatic cyc(input string tag, input logic [SELW-1:0] sel, input logic v, input logic w);
    exp_t e;
    e.y   = v ? ch(sel) : '0;
    e.sel = sel;
    e.v   = v;
    e.w   = w;
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: sample 1 ns after each edge and compare against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check({mon_e.tag, ".y"},     32'(y),       32'(mon_e.y));
      check({mon_e.tag, ".sel"},   32'(sel_out), 32'(mon_e.sel));
      check({mon_e.tag, ".valid"}, 32'(y_valid), 32'(mon_e.v));
      check({mon_e.tag, ".wrap"},  32'(wrap),    32'(mon_e.w));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    mode    = 1'b0;
    sel_in  = '0;
    en_mask = '0;
    dwell   = '0;
    d_in    = 16'h936C;
    @(posedge clk);
    #2;
    check("reset.y",     32'(y),       32'h0);
    check("reset.sel",   32'(sel_out), 32'h0);
    check("reset.valid", 32'(y_valid), 32'h0);
    check("reset.wrap",  32'(wrap),    32'h0);
    rst = 1'b0;

    // 1: manual select walks channels 0..3
    for (int i = 0; i < 4; i++) begin
      sel_in = SELW'(i);
      cyc("t1_manual", SELW'(i), 1'b1, 1'b0);
    end
    sel_in = 2'd0;
    cyc("t1_back0", 2'd0, 1'b1, 1'b0);

    // 2: full scan, dwell 3, with a live data change on channel 2
    mode    = 1'b1;
    en_mask = 4'b1111;
    dwell   = 16'd3;
    for (int e = 0; e <= 12; e++) begin
      if (e == 7) d_in = 16'h9F6C;
      cyc("t2_scan", SELW'((e / 3) % 4), 1'b1, (e == 12));
    end

    // 3: sparse mask, then drop the current channel mid-dwell
    en_mask = 4'b1010;
    dwell   = 16'd2;
    cyc("t3_sparse", 2'd1, 1'b1, 1'b0);
    cyc("t3_sparse", 2'd1, 1'b1, 1'b0);
    cyc("t3_sparse", 2'd3, 1'b1, 1'b0);
    cyc("t3_sparse", 2'd3, 1'b1, 1'b0);
    cyc("t3_sparse", 2'd1, 1'b1, 1'b1);
    cyc("t3_sparse", 2'd1, 1'b1, 1'b0);
    cyc("t3_sparse", 2'd3, 1'b1, 1'b0);
    en_mask = 4'b0010;
    cyc("t3_drop",   2'd1, 1'b1, 1'b1);
    cyc("t3_single", 2'd1, 1'b1, 1'b0);
    cyc("t3_single", 2'd1, 1'b1, 1'b1);

    // 4: dwell 0 with one channel pulses wrap every cycle, then halt
    dwell   = 16'd0;
    en_mask = 4'b0001;
    cyc("t4_dwell0", 2'd0, 1'b1, 1'b1);
    cyc("t4_dwell0", 2'd0, 1'b1, 1'b1);
    cyc("t4_dwell0", 2'd0, 1'b1, 1'b1);
    en_mask = 4'b0000;
    cyc("t4_halt", 2'd0, 1'b0, 1'b0);
    cyc("t4_halt", 2'd0, 1'b0, 1'b0);

    // 5: async reset mid-scan (channel 2, counter 1), then clean restart
    en_mask = 4'b1111;
    dwell   = 16'd2;
    cyc("t5_pre", 2'd0, 1'b1, 1'b0);
    cyc("t5_pre", 2'd0, 1'b1, 1'b0);
    cyc("t5_pre", 2'd1, 1'b1, 1'b0);
    cyc("t5_pre", 2'd1, 1'b1, 1'b0);
    cyc("t5_pre", 2'd2, 1'b1, 1'b0);
    cyc("t5_pre", 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_async.y",     32'(y),       32'h0);
    check("t5_async.sel",   32'(sel_out), 32'h0);
    check("t5_async.valid", 32'(y_valid), 32'h0);
    check("t5_async.wrap",  32'(wrap),    32'h0);
    cyc("t5_inrst", 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("t5_restart", 2'd0, 1'b1, 1'b0);
    cyc("t5_restart", 2'd0, 1'b1, 1'b0);
    cyc("t5_restart", 2'd1, 1'b1, 1'b0);

    // 6: manual 2 then scan over {0,3}: entry lands on 3, then wraps to 0
    mode   = 1'b0;
    sel_in = 2'd2;
    cyc("t6_manual", 2'd2, 1'b1, 1'b0);
    mode    = 1'b1;
    en_mask = 4'b1001;
    cyc("t6_entry", 2'd3, 1'b1, 1'b0);
    cyc("t6_dwell", 2'd3, 1'b1, 1'b0);
    cyc("t6_wrap",  2'd0, 1'b1, 1'b1);
    mode   = 1'b0;
    sel_in = 2'd1;
    cyc("t6_to_manual", 2'd1, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
